// File: rtl/median_pkg.sv
// Purpose: shared defaults and types for the median_filter / row_serializer pair.
// Contents: default geometry (WIDTH, COLS, ROWS), derived pixel width,
//           row-buffer occupancy state, RGB pixel payload.
package median_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_COLS  = 256;
    localparam int unsigned DEF_ROWS  = 256;
    localparam int unsigned DEF_PIX_W = 3 * DEF_WIDTH;

    // Row-buffer occupancy: ONE = active only, FULL = active + pending.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // One RGB pixel at the default component width; R in the top byte.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] r;
        logic [DEF_WIDTH-1:0] g;
        logic [DEF_WIDTH-1:0] b;
    } pixel_t;

endpackage

// File: rtl/row_serializer_if.sv
// Purpose: row-in / pixel-out handshake bundle for row_serializer.
// Signals: row_in/row_valid/row_ready (wide row handshake),
//          pix_data/pix_valid/pix_ready (pixel stream),
//          pix_sol/pix_eol/pix_sof/pix_eof (line/frame markers).
// Modports: slave = serializer side, master = source/sink side.
interface row_serializer_if
    import median_pkg::*;
#(
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned PIX_W = DEF_PIX_W
);

    logic [COLS*PIX_W-1:0] row_in;
    logic                  row_valid;
    logic                  row_ready;
    logic [PIX_W-1:0]      pix_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_sol;
    logic                  pix_eol;
    logic                  pix_sof;
    logic                  pix_eof;

    modport slave (
        input  row_in, row_valid, pix_ready,
        output row_ready, pix_data, pix_valid,
               pix_sol, pix_eol, pix_sof, pix_eof
    );

    modport master (
        output row_in, row_valid, pix_ready,
        input  row_ready, pix_data, pix_valid,
               pix_sol, pix_eol, pix_sof, pix_eof
    );

endinterface

// File: rtl/row_serializer_shift_reg.sv
// Purpose: row_shift_reg -- COLS*PIX_W load/shift register; the top slice is
//          the pixel currently presented.
// Ports: clk, rst_n (async active-low), i_clr (sync clear), i_load (parallel
//        load, wins over shift), i_shift (shift left by one pixel),
//        i_data (row to load), o_top (top PIX_W bits).
module row_shift_reg
    import median_pkg::*;
#(
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [COLS*PIX_W-1:0] i_data,
    output logic [PIX_W-1:0]      o_top
);

    localparam int unsigned ROW_BITS = COLS * PIX_W;

    logic [ROW_BITS-1:0] r_data;

    // Load has priority so a reload on the last-pixel handshake replaces the shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clr) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= r_data << PIX_W;
        end
    end

    assign o_top = r_data[ROW_BITS-1 -: PIX_W];

endmodule

// File: rtl/row_serializer.sv
// Purpose: double-buffered row-to-pixel serializer with line/frame markers.
// Ports: CLK (rising edge), RST (async active-low reset), SET (sync
//        active-low flush), bus (row_serializer_if.slave: wide row in,
//        pixel stream out with sol/eol/sof/eof).
module row_serializer
    import median_pkg::*;
#(
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SET,
    row_serializer_if.slave  bus
);

    localparam int unsigned PIX_W    = 3 * WIDTH;
    localparam int unsigned ROW_BITS = COLS * PIX_W;
    localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    occ_state_t          r_state;
    occ_state_t          w_state_nxt;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    w_col_nxt;
    logic [ROW_W-1:0]    r_row;
    logic [ROW_W-1:0]    w_row_nxt;
    logic [ROW_BITS-1:0] r_pend;
    logic [ROW_BITS-1:0] w_act_din;
    logic [PIX_W-1:0]    w_top;

    logic r_row_ready;
    logic r_pix_valid;
    logic r_sol;
    logic r_eol;
    logic r_sof;
    logic r_eof;

    logic w_flush;
    logic w_hs;
    logic w_last;
    logic w_acc;
    logic w_load_act;
    logic w_load_pend;
    logic w_sel_pend;
    logic w_vld_nxt;

    assign w_flush = !SET;
    assign w_hs    = r_pix_valid & bus.pix_ready;
    assign w_last  = w_hs & (r_col == COL_LAST);
    assign w_acc   = bus.row_valid & r_row_ready;

    // Occupancy state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Occupancy next state; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        if (w_flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) w_state_nxt = ONE;
                end
                ONE: begin
                    if (w_last && !w_acc)      w_state_nxt = EMPTY;
                    else if (!w_last && w_acc) w_state_nxt = FULL;
                end
                FULL: begin
                    if (w_last) w_state_nxt = ONE;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    // Buffer-routing decode. In ONE, an accept coinciding with the last
    // pixel goes straight to active so rows stream without a bubble.
    always_comb begin
        w_load_act  = 1'b0;
        w_load_pend = 1'b0;
        w_sel_pend  = 1'b0;
        if (!w_flush) begin
            case (r_state)
                EMPTY: begin
                    w_load_act = w_acc;
                end
                ONE: begin
                    w_load_act  = w_last & w_acc;
                    w_load_pend = !w_last & w_acc;
                end
                FULL: begin
                    w_load_act = w_last;
                    w_sel_pend = 1'b1;
                end
                default: begin
                    w_load_act = 1'b0;
                end
            endcase
        end
    end

    assign w_act_din = w_sel_pend ? r_pend : bus.row_in;

    // Pending row holds data only; its occupancy lives in r_state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_pend <= '0;
        end else if (w_load_pend) begin
            r_pend <= bus.row_in;
        end
    end

    row_shift_reg #(
        .COLS  (COLS),
        .PIX_W (PIX_W)
    ) u_active (
        .clk     (CLK),
        .rst_n   (RST),
        .i_clr   (w_flush),
        .i_load  (w_load_act),
        .i_shift (w_hs),
        .i_data  (w_act_din),
        .o_top   (w_top)
    );

    // Column / row counters; explicit wrap keeps non-power-of-two sizes correct.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (w_flush) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_hs) begin
            if (w_last) begin
                w_col_nxt = '0;
                w_row_nxt = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                w_col_nxt = r_col + COL_W'(1);
            end
        end
    end

    assign w_vld_nxt = (w_state_nxt != EMPTY);

    // Status and markers registered from next-state values, so they line up
    // with the pixel the active register presents after the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_col       <= '0;
            r_row       <= '0;
            r_row_ready <= 1'b1;
            r_pix_valid <= 1'b0;
            r_sol       <= 1'b0;
            r_eol       <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_row_ready <= (w_state_nxt != FULL);
            r_pix_valid <= w_vld_nxt;
            r_sol       <= w_vld_nxt & (w_col_nxt == '0);
            r_eol       <= w_vld_nxt & (w_col_nxt == COL_LAST);
            r_sof       <= w_vld_nxt & (w_col_nxt == '0) & (w_row_nxt == '0);
            r_eof       <= w_vld_nxt & (w_col_nxt == COL_LAST) & (w_row_nxt == ROW_LAST);
        end
    end

    assign bus.row_ready = r_row_ready;
    assign bus.pix_valid = r_pix_valid;
    assign bus.pix_data  = w_top;
    assign bus.pix_sol   = r_sol;
    assign bus.pix_eol   = r_eol;
    assign bus.pix_sof   = r_sof;
    assign bus.pix_eof   = r_eof;

endmodule

// File: tb/tb_row_serializer.sv
// Purpose: directed, table-driven bench for row_serializer at COLS=4, ROWS=2.
module tb_row_serializer;
    import median_pkg::*;

    localparam int unsigned TB_COLS  = 4;
    localparam int unsigned TB_ROWS  = 2;
    localparam int unsigned TB_PIX_W = 24;
    localparam int unsigned TB_ROW_B = TB_COLS * TB_PIX_W;

    typedef struct packed {
        logic        set_n;
        logic        rv;
        logic [1:0]  sel;
        logic        pr;
        logic        rr;
        logic        pv;
        logic [23:0] data;
        logic        sol;
        logic        eol;
        logic        sof;
        logic        eof;
    } vec_t;

    logic clk;
    logic rst_n;
    logic set_n;

    logic [TB_ROW_B-1:0] rows [3];
    vec_t                vecs [$];

    int n_vec;
    int n_bad;

    row_serializer_if #(.COLS(TB_COLS), .PIX_W(TB_PIX_W)) bus_if ();

    row_serializer #(
        .COLS  (TB_COLS),
        .ROWS  (TB_ROWS),
        .WIDTH (8)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .SET (set_n),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic rv, input logic [1:0] sel, input logic pr,
                       input logic rr, input logic pv, input logic [23:0] d,
                       input logic sol, input logic eol, input logic sof, input logic eof);
        vec_t v;
        v.set_n = s; v.rv = rv; v.sel = sel; v.pr = pr;
        v.rr = rr; v.pv = pv; v.data = d;
        v.sol = sol; v.eol = eol; v.sof = sof; v.eof = eof;
        vecs.push_back(v);
    endtask

    // Pixel data is only meaningful while pix_valid is expected high.
    task automatic check(input string name, input logic rr, input logic pv, input logic [23:0] d,
                         input logic sol, input logic eol, input logic sof, input logic eof);
        logic ok;
        ok = (bus_if.row_ready === rr) && (bus_if.pix_valid === pv) &&
             (bus_if.pix_sol === sol) && (bus_if.pix_eol === eol) &&
             (bus_if.pix_sof === sof) && (bus_if.pix_eof === eof) &&
             (!pv || (bus_if.pix_data === d));
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got rr=%b pv=%b data=%06h sol=%b eol=%b sof=%b eof=%b, want rr=%b pv=%b data=%06h sol=%b eol=%b sof=%b eof=%b",
                     name, bus_if.row_ready, bus_if.pix_valid, bus_if.pix_data,
                     bus_if.pix_sol, bus_if.pix_eol, bus_if.pix_sof, bus_if.pix_eof,
                     rr, pv, d, sol, eol, sof, eof);
        end
    endtask

    initial begin
        localparam logic [1:0] A = 2'd0;
        localparam logic [1:0] B = 2'd1;
        localparam logic [1:0] C = 2'd2;

        n_vec = 0;
        n_bad = 0;
        rows[0] = 96'h112233_445566_778899_AABBCC;
        rows[1] = 96'h010203_040506_070809_0A0B0C;
        rows[2] = 96'hD1D2D3_E1E2E3_F1F2F3_C1C2C3;

        // Basic row, back-to-back rows, row-counter wrap.
        add(1,1,A,1, 1,1,24'h112233, 1,0,1,0);
        add(1,1,B,1, 0,1,24'h445566, 0,0,0,0);
        add(1,1,C,1, 0,1,24'h778899, 0,0,0,0);
        add(1,1,C,1, 0,1,24'hAABBCC, 0,1,0,0);
        add(1,1,C,1, 1,1,24'h010203, 1,0,0,0);
        add(1,1,C,1, 0,1,24'h040506, 0,0,0,0);
        add(1,1,C,1, 0,1,24'h070809, 0,0,0,0);
        add(1,1,C,1, 0,1,24'h0A0B0C, 0,1,0,1);
        add(1,0,A,1, 1,1,24'hD1D2D3, 1,0,1,0);
        add(1,0,A,1, 1,1,24'hE1E2E3, 0,0,0,0);
        add(1,0,A,1, 1,1,24'hF1F2F3, 0,0,0,0);
        add(1,0,A,1, 1,1,24'hC1C2C3, 0,1,0,0);
        add(1,0,A,1, 1,0,24'h000000, 0,0,0,0);
        add(1,0,A,0, 1,0,24'h000000, 0,0,0,0);
        // Backpressure mid-row (frame row 1), then no-bubble straight-to-active.
        add(1,1,A,1, 1,1,24'h112233, 1,0,0,0);
        add(1,0,A,1, 1,1,24'h445566, 0,0,0,0);
        for (int i = 0; i < 5; i++) add(1,0,A,0, 1,1,24'h445566, 0,0,0,0);
        add(1,0,A,1, 1,1,24'h778899, 0,0,0,0);
        add(1,0,A,1, 1,1,24'hAABBCC, 0,1,0,1);
        add(1,1,B,1, 1,1,24'h010203, 1,0,1,0);
        add(1,0,A,0, 1,1,24'h010203, 1,0,1,0);
        // Full buffer under stall; third row waits until pending drains.
        add(1,1,C,0, 0,1,24'h010203, 1,0,1,0);
        add(1,1,A,0, 0,1,24'h010203, 1,0,1,0);
        add(1,1,A,1, 0,1,24'h040506, 0,0,0,0);
        add(1,1,A,1, 0,1,24'h070809, 0,0,0,0);
        add(1,1,A,1, 0,1,24'h0A0B0C, 0,1,0,0);
        add(1,1,A,1, 1,1,24'hD1D2D3, 1,0,0,0);
        add(1,1,A,1, 0,1,24'hE1E2E3, 0,0,0,0);
        add(1,0,A,1, 0,1,24'hF1F2F3, 0,0,0,0);
        add(1,0,A,1, 0,1,24'hC1C2C3, 0,1,0,1);
        add(1,0,A,1, 1,1,24'h112233, 1,0,1,0);
        // Flush with pending full, then a fresh frame.
        add(1,1,B,1, 0,1,24'h445566, 0,0,0,0);
        add(0,1,C,1, 1,0,24'h000000, 0,0,0,0);
        add(1,1,C,1, 1,1,24'hD1D2D3, 1,0,1,0);
        add(1,0,A,1, 1,1,24'hE1E2E3, 0,0,0,0);

        rst_n            = 1'b0;
        set_n            = 1'b1;
        bus_if.row_in    = '0;
        bus_if.row_valid = 1'b0;
        bus_if.pix_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (bus_if.pix_data !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %06h want 000000", bus_if.pix_data);
        end
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            set_n            = vecs[i].set_n;
            bus_if.row_valid = vecs[i].rv;
            bus_if.row_in    = rows[vecs[i].sel];
            bus_if.pix_ready = vecs[i].pr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].rr, vecs[i].pv, vecs[i].data,
                  vecs[i].sol, vecs[i].eol, vecs[i].sof, vecs[i].eof);
        end

        // Async reset between edges, mid-row: outputs must clear before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (bus_if.pix_data !== 24'h0) begin
            n_bad++;
            $display("FAIL async_reset_data: got %06h want 000000", bus_if.pix_data);
        end
        @(negedge clk);
        rst_n            = 1'b1;
        bus_if.row_valid = 1'b1;
        bus_if.row_in    = rows[0];
        bus_if.pix_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_pix0", 1'b1, 1'b1, 24'h112233, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus_if.row_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_pix1", 1'b1, 1'b1, 24'h445566, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
